// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the serial ALU: operation-select
//               encoding, controller state type and the default data width.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Default operand/result width
  localparam int DEFAULT_WIDTH = 8;

  // Operation-select encoding (S input)
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_XOR = 2'b10;
  localparam logic [1:0] ALU_NOR = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_1bit.sv
`default_nettype none
// ============================================================================
// Module      : alu_1bit
// Description : Single-bit combinational logic unit (AND / OR / XOR / NOR).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_1bit
  import alu_pkg::*;
(
  input  logic       i_a,
  input  logic       i_b,
  input  logic [1:0] i_sel,
  output logic       o_y
);

  // Select the logic function for one bit pair
  always_comb begin
    o_y = 1'b0;
    case (i_sel)
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_XOR: o_y = i_a ^ i_b;
      ALU_NOR: o_y = ~(i_a | i_b);
      default: o_y = 1'b0;
    endcase
  end

endmodule : alu_1bit
`default_nettype wire

// File: rtl/alu_8bits_serial.sv
`default_nettype none
// ============================================================================
// Module      : alu_8bits_serial
// Description : Bit-serial logic ALU. Captures an operand set on a valid/ready
//               handshake, streams one bit pair per cycle through a single
//               alu_1bit, and presents the full result with valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_8bits_serial
  import alu_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH+7:8] b,
  input  logic [1:0]       S,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [1:0]       r_sel;
  logic [WIDTH-1:0] r_res;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_y;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;
  logic [WIDTH-1:0] w_res_next;

  // Bit order: operands drain from one end, results enter at the other end so
  // that after WIDTH shifts every result bit sits at its own index.
  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_a_bit    = r_a[0];
      assign w_b_bit    = r_b[0];
      assign w_a_next   = {1'b0, r_a[WIDTH-1:1]};
      assign w_b_next   = {1'b0, r_b[WIDTH-1:1]};
      assign w_res_next = {w_y, r_res[WIDTH-1:1]};
    end else begin : g_msb_first
      assign w_a_bit    = r_a[WIDTH-1];
      assign w_b_bit    = r_b[WIDTH-1];
      assign w_a_next   = {r_a[WIDTH-2:0], 1'b0};
      assign w_b_next   = {r_b[WIDTH-2:0], 1'b0};
      assign w_res_next = {r_res[WIDTH-2:0], w_y};
    end
  endgenerate

  // The one and only bit-slice, fed from the serial operand path
  alu_1bit u_alu_1bit (
    .i_a   (w_a_bit),
    .i_b   (w_b_bit),
    .i_sel (r_sel),
    .o_y   (w_y)
  );

  // Controller and datapath: capture, shift WIDTH times, hold until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sel   <= ALU_AND;
      r_res   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_sel   <= S;
            r_cnt   <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_a   <= w_a_next;
          r_b   <= w_b_next;
          r_res <= w_res_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Handshake/status outputs decode straight from the state register
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == SHIFT) || (r_state == DONE);
  assign Result    = r_res;

endmodule : alu_8bits_serial
`default_nettype wire

// File: tb/tb_alu_8bits_serial.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_alu_8bits_serial
// Description : Self-checking bench; one LSB-first and one MSB-first instance
//               share all inputs and are checked against a bitwise model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_8bits_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [7:0]  a = '0;
  logic [15:8] b = '0;
  logic [1:0]  S = '0;

  logic        in_ready_l, out_valid_l, busy_l;
  logic [7:0]  result_l;
  logic        in_ready_m, out_valid_m, busy_m;
  logic [7:0]  result_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_8bits_serial #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_l),
    .a(a), .b(b), .S(S), .out_valid(out_valid_l), .out_ready(out_ready),
    .Result(result_l), .busy(busy_l)
  );

  alu_8bits_serial #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
    .a(a), .b(b), .S(S), .out_valid(out_valid_m), .out_ready(out_ready),
    .Result(result_m), .busy(busy_m)
  );

  // Reference: plain bitwise operation selected by S
  function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return x & y;
      2'b01:   return x | y;
      2'b10:   return x ^ y;
      default: return ~(x | y);
    endcase
  endfunction

  // Drive one operation; lat counts posedges with the handshake edge as 1
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [1:0] ts,
                        input int stall, input bit scramble, input bit hold,
                        output logic [7:0] rl, output logic [7:0] rm,
                        output int lat, output bit ok);
    int n;
    ok = 1'b1; lat = 0; rl = '0; rm = '0;
    @(negedge clk);
    n = 0;
    while (!in_ready_l && n < 50) begin @(negedge clk); n++; end
    if (!in_ready_l) begin ok = 1'b0; return; end
    a = ta; b = tb_v; S = ts; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); lat = 1;
    @(negedge clk); in_valid = 1'b0;
    n = 0;
    while (!out_valid_l && n < 50) begin
      if (scramble) begin
        a = 8'($urandom); b = 8'($urandom); S = 2'($urandom);
        in_valid = 1'($urandom); out_ready = 1'($urandom);
      end
      @(posedge clk); lat++;
      @(negedge clk); n++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    if (!out_valid_l) begin ok = 1'b0; return; end
    rl = result_l; rm = result_m;
    if (hold) return;
    repeat (stall) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready_l !== 1'b1 || in_ready_m !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b/%b exp 1", in_ready_l, in_ready_m); end
    checks++; if (out_valid_l !== 1'b0 || out_valid_m !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b/%b exp 0", out_valid_l, out_valid_m); end
    checks++; if (busy_l !== 1'b0 || busy_m !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b exp 0", busy_l, busy_m); end
    checks++; if (result_l !== 8'h00 || result_m !== 8'h00) begin errors++; $display("FAIL reset_result got %h/%h exp 00", result_l, result_m); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_xor_basic();
    logic [7:0] rl, rm; int lat; bit ok;
    run_op(8'hA5, 8'h3C, 2'b10, 0, 1'b0, 1'b0, rl, rm, lat, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL xor_timeout got %b exp 1", ok); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL xor_latency got %0d exp 9", lat); end
    checks++; if (rl !== 8'h99) begin errors++; $display("FAIL xor_result_lsb got %h exp 99", rl); end
    checks++; if (rm !== 8'h99) begin errors++; $display("FAIL xor_result_msb got %h exp 99", rm); end
  endtask

  task automatic test_opcode_sweep();
    logic [7:0] rl, rm, exp_v; int lat; bit ok;
    logic [1:0] ops [3];
    logic [7:0] exps [3];
    ops[0] = 2'b00; exps[0] = 8'hC0;
    ops[1] = 2'b01; exps[1] = 8'hFC;
    ops[2] = 2'b11; exps[2] = 8'h03;
    for (int i = 0; i < 3; i++) begin
      exp_v = exps[i];
      run_op(8'hF0, 8'hCC, ops[i], 1, 1'b0, 1'b0, rl, rm, lat, ok);
      checks++; if (rl !== exp_v || ok !== 1'b1) begin errors++; $display("FAIL sweep_lsb S=%b got %h exp %h", ops[i], rl, exp_v); end
      checks++; if (rm !== exp_v || ok !== 1'b1) begin errors++; $display("FAIL sweep_msb S=%b got %h exp %h", ops[i], rm, exp_v); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] rl, rm; int lat; bit ok; int n;
    run_op(8'h5A, 8'h0F, 2'b01, 0, 1'b0, 1'b1, rl, rm, lat, ok);
    checks++; if (rl !== 8'h5F || rm !== 8'h5F || ok !== 1'b1) begin errors++; $display("FAIL bp_first got %h/%h exp 5f", rl, rm); end
    a = 8'hC3; b = 8'h3C; S = 2'b10; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (out_valid_l !== 1'b1 || in_ready_l !== 1'b0 || in_ready_m !== 1'b0) begin errors++; $display("FAIL bp_hold_flags cyc %0d got ov=%b ir=%b exp ov=1 ir=0", i, out_valid_l, in_ready_l); end
      checks++; if (result_l !== 8'h5F || result_m !== 8'h5F) begin errors++; $display("FAIL bp_hold_result cyc %0d got %h/%h exp 5f", i, result_l, result_m); end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++; if (in_ready_l !== 1'b1 || out_valid_l !== 1'b0) begin errors++; $display("FAIL bp_release got ir=%b ov=%b exp ir=1 ov=0", in_ready_l, out_valid_l); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (busy_l !== 1'b1 || busy_m !== 1'b1) begin errors++; $display("FAIL bp_accept got busy %b/%b exp 1", busy_l, busy_m); end
    n = 0;
    while (!out_valid_l && n < 50) begin @(negedge clk); n++; end
    checks++; if (result_l !== 8'hFF || result_m !== 8'hFF || out_valid_l !== 1'b1) begin errors++; $display("FAIL bp_second got %h/%h exp ff", result_l, result_m); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_operand_change();
    logic [7:0] rl, rm; int lat; bit ok;
    run_op(8'h6B, 8'hD2, 2'b00, 2, 1'b1, 1'b0, rl, rm, lat, ok);
    checks++; if (rl !== 8'h42 || ok !== 1'b1) begin errors++; $display("FAIL opchg_lsb got %h exp 42", rl); end
    checks++; if (rm !== 8'h42 || ok !== 1'b1) begin errors++; $display("FAIL opchg_msb got %h exp 42", rm); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] rl, rm; int lat; bit ok;
    @(negedge clk);
    a = 8'h33; b = 8'h0F; S = 2'b10; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy_l !== 1'b1) begin errors++; $display("FAIL mrst_busy_before got %b exp 1", busy_l); end
    rst_n = 1'b0;
    #1;
    checks++; if (in_ready_l !== 1'b1 || in_ready_m !== 1'b1 || out_valid_l !== 1'b0 || out_valid_m !== 1'b0) begin errors++; $display("FAIL mrst_flags got ir=%b ov=%b exp ir=1 ov=0", in_ready_l, out_valid_l); end
    checks++; if (result_l !== 8'h00 || result_m !== 8'h00) begin errors++; $display("FAIL mrst_result got %h/%h exp 00", result_l, result_m); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'hFF, 8'h00, 2'b01, 0, 1'b0, 1'b0, rl, rm, lat, ok);
    checks++; if (rl !== 8'hFF || rm !== 8'hFF || ok !== 1'b1) begin errors++; $display("FAIL mrst_after got %h/%h exp ff", rl, rm); end
    checks++; if (lat !== 9) begin errors++; $display("FAIL mrst_latency got %0d exp 9", lat); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] oa [3];
    logic [7:0] ob [3];
    logic [1:0] os [3];
    logic [7:0] got [3];
    int hs [3];
    int k, j, cyc;
    oa[0] = 8'h12; ob[0] = 8'h34; os[0] = 2'b10;
    oa[1] = 8'hF0; ob[1] = 8'h0F; os[1] = 2'b01;
    oa[2] = 8'hAA; ob[2] = 8'h0F; os[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin got[i] = '0; hs[i] = 0; end
    k = 0; j = 0; cyc = 0;
    out_ready = 1'b1;
    @(negedge clk);
    while (j < 3 && cyc < 80) begin
      if (out_valid_l) begin got[j] = result_l; j++; end
      if (in_ready_l && k < 3) begin
        a = oa[k]; b = ob[k]; S = os[k]; in_valid = 1'b1; hs[k] = cyc; k++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk); cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (j !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", j); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (hs[i+1] - hs[i] !== 10) begin errors++; $display("FAIL b2b_period op %0d got %0d exp 10", i, hs[i+1] - hs[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got[i] !== ref_op(oa[i], ob[i], os[i])) begin errors++; $display("FAIL b2b_result op %0d got %h exp %h", i, got[i], ref_op(oa[i], ob[i], os[i])); end
    end
  endtask

  task automatic test_random();
    logic [7:0] ra, rb, rl, rm, exp_v; logic [1:0] rs; int lat; bit ok;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 2'($urandom);
      exp_v = ref_op(ra, rb, rs);
      run_op(ra, rb, rs, int'($urandom_range(0, 3)), 1'($urandom), 1'b0, rl, rm, lat, ok);
      checks++; if (rl !== exp_v || ok !== 1'b1) begin errors++; $display("FAIL rand_lsb #%0d a=%h b=%h S=%b got %h exp %h", i, ra, rb, rs, rl, exp_v); end
      checks++; if (rm !== exp_v || ok !== 1'b1) begin errors++; $display("FAIL rand_msb #%0d a=%h b=%h S=%b got %h exp %h", i, ra, rb, rs, rm, exp_v); end
      checks++; if (lat !== 9) begin errors++; $display("FAIL rand_latency #%0d got %0d exp 9", i, lat); end
    end
  endtask

  initial begin
    test_reset();
    test_xor_basic();
    test_opcode_sweep();
    test_backpressure();
    test_operand_change();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_alu_8bits_serial
`default_nettype wire

// File: doc/alu_8bits_serial.md
ALU_8BITS_SERIAL -- requirements
Module: alu_8bits_serial

Interface
REQ-001 Parameter WIDTH, default 8: operand/result width in bits; the bit-serial counter range is 0..WIDTH-1.
REQ-002 Parameter LSB_FIRST, default 1: 1 processes bit 0 first; 0 processes bit WIDTH-1 first.
REQ-003 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1: reset; asynchronous assertion, active-low.
REQ-005 Port in_valid, input, 1: operand set a/b/S is valid.
REQ-006 Port in_ready, output, 1: block can accept an operand set.
REQ-007 Port a, input, WIDTH: operand A.
REQ-008 Port b, input, WIDTH (declared [WIDTH+7:8]): operand B; the bit-numbering convention matches the parallel 8-bit ALU.
REQ-009 Port S, input, 2: operation select; 00 AND, 01 OR, 10 XOR, 11 NOR.
REQ-010 Port out_valid, output, 1: Result is valid.
REQ-011 Port out_ready, input, 1: consumer accepts Result.
REQ-012 Port Result, output, WIDTH: operation result.
REQ-013 Port busy, output, 1: high in SHIFT or DONE.

Function
REQ-014 States SHALL be IDLE, SHIFT and DONE, and no other states SHALL be reachable.
REQ-015 in_ready SHALL equal (state==IDLE).
REQ-016 The input handshake SHALL occur on in_valid && in_ready; on that edge the block SHALL capture a, b and S into registers, clear the bit counter and enter SHIFT.
REQ-017 While in SHIFT, the block SHALL pass one bit pair per cycle through the single alu_1bit instance using the captured S, shift the result bit into the result shift register, shift the operand registers and increment the counter.
REQ-018 After WIDTH SHIFT cycles (counter==WIDTH-1 processed), the block SHALL enter DONE; out_valid SHALL then be high and Result SHALL hold the full WIDTH-bit value.
REQ-019 Latency SHALL be WIDTH+1 cycles from the input-handshake edge to out_valid high (9 for WIDTH=8).
REQ-020 While in DONE, out_valid SHALL stay high and Result SHALL stay stable until out_valid && out_ready, after which the state SHALL be IDLE on the next edge.
REQ-021 Back-to-back operation: in_ready SHALL rise in the cycle after the output handshake, with no skid buffer and a throughput of one operation per WIDTH+2 cycles minimum.
REQ-022 Changes on a, b, S or in_valid outside the input handshake SHALL NOT affect an operation in progress.
REQ-023 out_ready SHALL be ignored outside DONE, and in_valid SHALL be ignored outside IDLE.
REQ-024 Result SHALL equal the bitwise operation of the captured a and b, bit-for-bit identical to the parallel 8-bit ALU for every S and LSB_FIRST value.

Reset
REQ-025 When rst_n is low, the block SHALL immediately enter IDLE and clear the counter, the operand registers and the result register.
REQ-026 After reset, the outputs SHALL be in_ready=1, out_valid=0, busy=0 and Result=0.
REQ-027 Reset asserted during SHIFT or DONE SHALL abort the operation with no partial Result exposed; the first handshake after reset release SHALL start a fresh operation.
REQ-028 Reset deassertion SHALL be synchronised externally; the block assumes release is synchronous to clk.

Structure
REQ-029 The shared package alu_pkg SHALL hold the S encoding constants (ALU_AND, ALU_OR, ALU_XOR, ALU_NOR), the state enum typedef and the default WIDTH.
REQ-030 The block SHALL contain exactly one existing alu_1bit sub-module instance, driven from the serial shift path, with no other sub-modules.
REQ-031 The counter width SHALL be $clog2(WIDTH).

Verification
REQ-032 Basic XOR test: reset, then a=8'hA5, b=8'h3C, S=10, in_valid pulse -> out_valid high exactly 9 cycles after the handshake edge with Result=8'h99.
REQ-033 Opcode sweep test: a=8'hF0, b=8'hCC with S=00/01/11 -> Result=8'hC0 / 8'hFC / 8'h03.
REQ-034 Backpressure test: out_ready held low for 5 cycles in DONE, in_valid held high with new operands -> Result stable at its value, in_ready low, new operands ignored; after out_ready=1 the next operation is accepted.
REQ-035 Operand change test: a and b toggled every cycle during SHIFT -> Result reflects only the operands captured at the handshake.
REQ-036 Mid-operation reset test: rst_n pulsed low at SHIFT cycle 4 -> same-cycle in_ready=1, out_valid=0, Result=0; a subsequent a=8'hFF, b=8'h00, S=01 gives Result=8'hFF.
REQ-037 Random test: 1000 random a/b/S with random out_ready stalls, for LSB_FIRST=0 and 1 -> every Result matches a bitwise reference model.
